i2c_tof_target: RTL and testbench
=================================

Name: i2c_tof_target

Overview:
- I2C target (slave) that exposes the ToF aggregator's per-sensor results to an external I2C host (MCU) through a small register map.
- Sits beside the ToF comm block. It drives that block's sensor select (tof_index) and samples its packed data and ready outputs.
- Oversampled design: the host's SCL/SDA are synchronised to clk; the block never drives SCL.

Parameters:
- TARGET_ADDR, 7'h2A, 7-bit I2C address this block responds to.
- DEVICE_ID, 8'hD5, constant returned by the ID register.
- FILT_LEN, 4, clk cycles a filtered SCL/SDA level must be stable (used only with the optional feature).

Ports:
- clk  in  1  system clock; must be at least 20x SCL.
- reset  in  1  synchronous, active-high.
- scl_i  in  1  SCL from pad (asynchronous).
- sda_i  in  1  SDA from pad (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- tof_index  out  3  sensor select to the ToF comm block.
- data_in  in  22  {sensor_index[5:0], distance[15:0]} of the selected sensor.
- ready_in  in  8  per-sensor data-ready flags.
- busy  out  1  high from START until STOP when addressed.

Behaviour:
- Reset values: sda_oe=0, tof_index=0, busy=0, pointer=0x00, all snapshots=0, FSM=IDLE. Reset mid-transfer releases SDA on the next clk.
- Input sync: 2-FF synchroniser on scl_i and sda_i. Edges are detected on the synced (or filtered) levels.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are honoured in every state. START forces ADDR and resets the bit counter; STOP forces IDLE, sda_oe=0, busy=0.
- Data bits are sampled on the SCL rising edge, MSB first. sda_oe changes exactly 1 clk after a detected SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT, IGNORE.
- ADDR: shift 8 bits.
  - addr==TARGET_ADDR: go to ADDR_ACK and drive ACK (sda_oe=1) from the 8th falling edge to the 9th falling edge.
  - Mismatch: go to IGNORE (no drive) until START or STOP.
- After ADDR_ACK:
  - R/W=0 goes to PTR. Its byte loads the pointer, ACKed, then WDATA.
  - R/W=1 goes to RDATA.
- WDATA: each byte is written to the pointer location and ACKed, then pointer+1. All writable and read-only addresses are ACKed; writes to read-only addresses are dropped.
- RDATA: drive the bit of the current byte (sda_oe = ~bit) after each falling edge. After 8 bits, release SDA and sample the host ACK on the 9th rising edge.
  - ACK: pointer+1, continue in RDATA.
  - NACK: go to IGNORE until STOP or START.
- Pointer is 8-bit and wraps 0xFF to 0x00.
- Register map:
  - 0x00 STATUS (RO): ready snapshot.
  - 0x01 CTRL (RW): bits [2:0] = tof_index; bits [7:3] read 0.
  - 0x02 DIST_LO (RO): distance[7:0].
  - 0x03 DIST_HI (RO): distance[15:8].
  - 0x04 SIDX (RO): {2'b00, sensor_index}.
  - 0x05 ID (RO): DEVICE_ID.
  - 0x06-0xFF: read 0x00, writes ignored.
- Snapshots:
  - ready_in is latched into STATUS when the byte for address 0x00 is loaded for transmission.
  - data_in is latched into a 22-bit shadow when the byte for 0x02 is loaded. 0x03 and 0x04 return the shadow, so a burst read of 0x02..0x04 is coherent.
- tof_index updates 1 clk after the CTRL write's 8th data bit is sampled. The aggregator's ready flag for that index then clears.
- Simultaneous START and STOP detection is impossible (single SDA edge). An SCL edge in the same cycle as START/STOP is ignored.

Optional Feature:
- Macro: I2C_TOF_TARGET_GLITCH_FILTER_EN.
- Defined: each synced line passes a FILT_LEN-cycle stability filter. A new level is accepted only after FILT_LEN consecutive equal samples, which rejects pulses shorter than FILT_LEN clk.
- Undefined: the 2-FF synced levels are used directly; latency is FILT_LEN cycles shorter.

Test Plan:
- Write: START, 0x54, 0x01, 0x05, STOP -> three ACKs observed, tof_index=3'd5 after 8th data bit, busy low after STOP.
- Burst read:
  - data_in=22'h2A_1234 setup: write pointer 0x02, repeated START, 0x55, read 3 bytes ACK/ACK/NACK, STOP.
  - Required response: host receives 0x34, 0x12, 0x2A. data_in changed to 22'h00_FFFF after the first byte must not affect the bytes.
- Wrong address: START, 0x20 -> sda_oe stays 0 through ACK slot and the following byte; next START with 0x54 ACKed normally.
- STATUS/ID: ready_in=8'h81, set pointer 0x00, read 6 bytes -> 0x81, CTRL value, DIST_LO, DIST_HI, SIDX, 0xD5. Pointer 0xFF read twice -> 0x00, 0x00 (wrap to STATUS).
- Reset during RDATA while sda_oe=1 -> sda_oe=0 the next clk, FSM IDLE, tof_index=0.
- With I2C_TOF_TARGET_GLITCH_FILTER_EN: a 2-clk low glitch on SDA while SCL is high -> no START/STOP detected, transfer continues. Without the macro the same glitch aborts to IDLE.

Source files
------------

// File: rtl/i2c_tof_target.sv
// ---------------------------------------------------------------------------
// i2c_tof_target
//   I2C target that lets an external host read the ToF aggregator results
//   through a small register map. The host's SCL/SDA are oversampled on clk;
//   SDA is driven open-drain through sda_oe, and SCL is never driven.
//
// Ports
//   clk        system clock (at least 20x SCL)
//   reset      synchronous, active-high
//   scl_i      SCL from pad (asynchronous)
//   sda_i      SDA from pad (asynchronous)
//   sda_oe     1 = pull SDA low, 0 = release
//   tof_index  sensor select to the ToF comm block (CTRL[2:0])
//   data_in    {sensor_index[5:0], distance[15:0]} of the selected sensor
//   ready_in   per-sensor data-ready flags
//   busy       high while this target is addressed, cleared by STOP
//
// Register map: 0x00 STATUS (RO), 0x01 CTRL (RW, [2:0]), 0x02 DIST_LO,
//   0x03 DIST_HI, 0x04 SIDX, 0x05 ID; 0x06-0xFF read 0x00.
//
// Build option: define I2C_TOF_TARGET_GLITCH_FILTER_EN to pass each synced
//   line through a FILT_LEN-cycle stability filter before edge detection.
// ---------------------------------------------------------------------------
module i2c_tof_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter logic [7:0] DEVICE_ID   = 8'hD5,
    parameter int         FILT_LEN    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [2:0]  tof_index,
    input  logic [21:0] data_in,
    input  logic [7:0]  ready_in,
    output logic        busy
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RACK_WAIT = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    // Line vectors: bit 0 = SCL, bit 1 = SDA. Idle bus level is high.
    logic [1:0] sync1_q, sync2_q, line_f, line_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            line_prev_q <= 2'b11;
        end else begin
            sync1_q     <= {sda_i, scl_i};
            sync2_q     <= sync1_q;
            line_prev_q <= line_f;
        end
    end

`ifdef I2C_TOF_TARGET_GLITCH_FILTER_EN
    localparam int FCNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    // A new level is taken only after FILT_LEN consecutive samples that
    // differ from the current filtered level; shorter pulses are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic [FCNT_W-1:0] cnt_q, cnt_d;
            logic              lvl_q, lvl_d;

            always_comb begin
                cnt_d = '0;
                lvl_d = lvl_q;
                if (sync2_q[gi] != lvl_q) begin
                    if (cnt_q == FCNT_W'(FILT_LEN - 1)) begin
                        lvl_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign line_f[gi] = lvl_q;
        end
    endgenerate
`else
    assign line_f = sync2_q;
    // FILT_LEN only shapes the optional filter.
    logic filt_len_unused;
    assign filt_len_unused = (FILT_LEN > 0);
`endif

    logic scl, sda, start_det, stop_det, scl_rise, scl_fall;
    assign scl       = line_f[0];
    assign sda       = line_f[1];
    // START/STOP need SCL high on both samples, so they never share a cycle
    // with an SCL edge; the edge terms are still gated to make that explicit.
    assign start_det = scl && line_prev_q[0] &&  line_prev_q[1] && !sda;
    assign stop_det  = scl && line_prev_q[0] && !line_prev_q[1] &&  sda;
    assign scl_rise  =  scl && !line_prev_q[0] && !start_det && !stop_det;
    assign scl_fall  = !scl &&  line_prev_q[0] && !start_det && !stop_det;

    logic [3:0]  state_q, state_d, bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d, rd_byte;
    logic [21:0] shadow_q, shadow_d;
    logic [2:0]  tof_index_q, tof_index_d;
    logic        sda_oe_q, sda_oe_d, busy_q, busy_d, rw_q, rw_d, load;

    // Byte presented for transmission at the current pointer. STATUS and
    // DIST_LO come straight from the live inputs at load time; the loaded
    // byte in tx_q is the STATUS snapshot, shadow_q holds the data snapshot.
    always_comb begin
        case (ptr_q)
            8'h00:   rd_byte = ready_in;
            8'h01:   rd_byte = {5'b00000, tof_index_q};
            8'h02:   rd_byte = data_in[7:0];
            8'h03:   rd_byte = shadow_q[15:8];
            8'h04:   rd_byte = {2'b00, shadow_q[21:16]};
            8'h05:   rd_byte = DEVICE_ID;
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        shadow_d    = shadow_q;
        tof_index_d = tof_index_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        load        = 1'b0;

        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // CTRL takes effect as soon as its last bit is in.
                        if (state_q == S_WDATA && bit_cnt_q == 4'd7 && ptr_q == 8'h01) begin
                            tof_index_d = {shift_q[1:0], sda};
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                state_d = S_ADDR_ACK;
                                rw_d    = shift_q[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d  = S_IGNORE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == S_PTR) begin
                            state_d = S_PTR_ACK;
                            ptr_d   = shift_q;
                        end else begin
                            state_d = S_WDATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        if (rw_q) begin
                            state_d = S_RDATA;
                            load    = 1'b1;
                        end else begin
                            state_d = S_PTR;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = S_WDATA;
                        if (state_q == S_WDATA_ACK) begin
                            ptr_d = ptr_q + 8'd1;
                        end
                    end
                end
                S_RDATA: begin
                    // bit_cnt_q counts bits already placed on the bus.
                    if (scl_fall) begin
                        if (bit_cnt_q < 4'd8) begin
                            sda_oe_d  = ~tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RACK_WAIT;
                        end
                    end
                end
                S_RACK_WAIT: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_d = S_IGNORE;
                        end else begin
                            ptr_d = ptr_q + 8'd1;
                        end
                    end else if (scl_fall) begin
                        state_d = S_RDATA;
                        load    = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // Load the next read byte and put its MSB on the bus at once.
            if (load) begin
                tx_d      = {rd_byte[6:0], 1'b0};
                sda_oe_d  = ~rd_byte[7];
                bit_cnt_d = 4'd1;
                if (ptr_q == 8'h02) begin
                    shadow_d = data_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            shadow_q    <= 22'd0;
            tof_index_q <= 3'd0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            shadow_q    <= shadow_d;
            tof_index_q <= tof_index_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign tof_index = tof_index_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_tof_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_tof_target
//   Bit-banged I2C host around i2c_tof_target. Each stimulus step pushes its
//   expected response into a queue; a monitor process pairs it with the
//   observed bus/port value and compares. A register-level model (pointer,
//   CTRL, data snapshot) supplies every expected byte.
// ---------------------------------------------------------------------------
module tb_i2c_tof_target;
    localparam int Q = 100;   // quarter SCL period in ns (10 clk)

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        sda_h = 1'b1;
    logic        sda_oe, busy, sda_bus;
    logic [2:0]  tof_index;
    logic [21:0] data_in = 22'd0;
    logic [7:0]  ready_in = 8'h00;

    assign sda_bus = sda_h & ~sda_oe;

    always #5 clk = ~clk;

    i2c_tof_target dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .tof_index (tof_index),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .busy      (busy)
    );

    // ---------------- scoreboard ----------------
    string name_q[$];
    int    exp_q[$];
    int    obs_q[$];
    int    total = 0;
    int    bad = 0;

    task automatic expect_val(input string nm, input int e);
        name_q.push_back(nm);
        exp_q.push_back(e);
    endtask

    task automatic observe(input int o);
        obs_q.push_back(o);
    endtask

    initial begin : monitor
        string nm;
        int    e, o;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                o  = obs_q.pop_front();
                total++;
                if (e != o) begin
                    bad++;
                    $display("FAIL %s: got 0x%0h required 0x%0h", nm, o, e);
                end
            end
        end
    end

    // Watch for any SDA drive while the target should be ignoring the bus.
    logic watch = 1'b0, oe_clr = 1'b0, oe_seen;
    always @(posedge clk) begin
        if (oe_clr) oe_seen <= 1'b0;
        else if (watch && sda_oe) oe_seen <= 1'b1;
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_ptr = 8'h00;
    logic [2:0]  m_ctrl = 3'd0;
    logic [21:0] m_shadow = 22'd0;
    logic [7:0]  wr_q[$];

    function automatic logic [7:0] m_read();
        case (m_ptr)
            8'h00: return ready_in;
            8'h01: return {5'd0, m_ctrl};
            8'h02: begin m_shadow = data_in; return data_in[7:0]; end
            8'h03: return m_shadow[15:8];
            8'h04: return {2'b00, m_shadow[21:16]};
            8'h05: return 8'hD5;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- host bus tasks ----------------
    task automatic bit_io(input logic b, output logic s);
        sda_h = b; #Q; scl = 1'b1; #Q; s = sda_bus; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_start();
        sda_h = 1'b1; #Q; scl = 1'b1; #Q; sda_h = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_h = 1'b0; #Q; scl = 1'b1; #Q; sda_h = 1'b1; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        expect_val(nm, exp_ack ? 0 : 1);
        bit_io(1'b1, s);
        observe(int'(s));
    endtask

    task automatic recv_byte(input logic [7:0] e, input logic host_ack, input string nm);
        logic [7:0] v;
        logic       s;
        expect_val(nm, int'(e));
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            v[i] = s;
        end
        bit_io(~host_ack, s);
        observe(int'(v));
    endtask

    task automatic do_write(input logic [7:0] p);
        $display("txn write ptr=%02h n=%0d", p, wr_q.size());
        i2c_start();
        send_byte(8'h54, 1'b1, "ack_addr_w");
        expect_val("busy_addressed", 1); observe(int'(busy));
        send_byte(p, 1'b1, "ack_ptr");
        m_ptr = p;
        foreach (wr_q[k]) begin
            send_byte(wr_q[k], 1'b1, "ack_wdata");
            if (m_ptr == 8'h01) m_ctrl = wr_q[k][2:0];
            m_ptr = m_ptr + 8'd1;
            expect_val("tof_index", int'(m_ctrl)); observe(int'(tof_index));
        end
        i2c_stop();
        expect_val("busy_after_stop", 0); observe(int'(busy));
    endtask

    task automatic do_read(input logic [7:0] p, input int n, input logic set_ptr, input logic chg);
        logic [7:0] e;
        $display("txn read ptr=%02h n=%0d set_ptr=%0d", set_ptr ? p : m_ptr, n, set_ptr);
        i2c_start();
        if (set_ptr) begin
            send_byte(8'h54, 1'b1, "ack_addr_w");
            send_byte(p, 1'b1, "ack_ptr");
            m_ptr = p;
            i2c_start();
        end
        send_byte(8'h55, 1'b1, "ack_addr_r");
        for (int k = 0; k < n; k++) begin
            e = m_read();
            recv_byte(e, k != n - 1, "rd_byte");
            if (k != n - 1) m_ptr = m_ptr + 8'd1;
            if (chg && k == 0) data_in = 22'h00FFFF;
        end
        i2c_stop();
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic s;
        logic [7:0] b;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_val("rst_sda_oe", 0);    observe(int'(sda_oe));
        expect_val("rst_tof_index", 0); observe(int'(tof_index));
        expect_val("rst_busy", 0);      observe(int'(busy));

        // Pointer starts at STATUS.
        ready_in = 8'($urandom);
        do_read(8'h00, 1, 1'b0, 1'b0);

        // CTRL write.
        wr_q = '{8'h05};
        do_write(8'h01);

        // Coherent burst read of the distance/index snapshot.
        data_in = 22'h2A1234;
        do_read(8'h02, 3, 1'b1, 1'b1);

        // Wrong address, then a normal transfer after repeated START.
        $display("txn wrong address 0x20");
        oe_clr = 1'b1; @(negedge clk); oe_clr = 1'b0; watch = 1'b1;
        i2c_start();
        for (int i = 7; i >= 0; i--) begin b = 8'h20; bit_io(b[i], s); end
        expect_val("nak_addr", 1); bit_io(1'b1, s); observe(int'(s));
        send_byte(8'hFF, 1'b0, "ignore_byte");
        watch = 1'b0;
        expect_val("ignore_oe", 0); observe(int'(oe_seen));
        i2c_start();
        send_byte(8'h54, 1'b1, "ack_after_ignore");
        send_byte(8'h03, 1'b1, "ack_ptr");
        m_ptr = 8'h03;
        i2c_stop();

        // Full register map sweep and pointer wrap.
        ready_in = 8'h81;
        do_read(8'h00, 6, 1'b1, 1'b0);
        ready_in = 8'h00;
        do_read(8'hFF, 2, 1'b1, 1'b0);

        // SDA glitch during a CTRL data bit with SCL high.
        wr_q = '{8'h01};
        do_write(8'h01);
        $display("txn glitch on CTRL write");
        i2c_start();
        send_byte(8'h54, 1'b1, "ack_addr_w");
        send_byte(8'h01, 1'b1, "ack_ptr");
        m_ptr = 8'h01;
        b = 8'h86;
        sda_h = 1'b1; #Q; scl = 1'b1; #(Q/2);
        sda_h = 1'b0; @(negedge clk); @(negedge clk); sda_h = 1'b1;
        #(Q/2); scl = 1'b0; #Q;
        for (int i = 6; i >= 0; i--) bit_io(b[i], s);
`ifdef I2C_TOF_TARGET_GLITCH_FILTER_EN
        expect_val("glitch_ack", 0);
        m_ctrl = b[2:0];
        m_ptr  = 8'h02;
`else
        expect_val("glitch_ack", 1);
`endif
        bit_io(1'b1, s); observe(int'(s));
        i2c_stop();
        expect_val("glitch_tof_index", int'(m_ctrl)); observe(int'(tof_index));

        // Randomised register traffic.
        for (int t = 0; t < 14; t++) begin
            ready_in = 8'($urandom);
            data_in  = 22'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    wr_q = {};
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++) wr_q.push_back(8'($urandom));
                    do_write(($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 7)));
                end
                1: do_read(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7)),
                           int'($urandom_range(1, 4)), 1'b1, 1'b0);
                default: do_read(8'h00, int'($urandom_range(1, 3)), 1'b0, 1'b0);
            endcase
        end

        // Reset while the target is driving a read bit low.
        wr_q = '{8'($urandom_range(1, 7))};
        do_write(8'h01);
        $display("txn reset during read");
        i2c_start();
        send_byte(8'h54, 1'b1, "ack_addr_w");
        send_byte(8'h04, 1'b1, "ack_ptr");
        i2c_start();
        send_byte(8'h55, 1'b1, "ack_addr_r");
        expect_val("rd_drive_low", 1); observe(int'(sda_oe));
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_ptr = 8'h00; m_ctrl = 3'd0; m_shadow = 22'd0;
        expect_val("reset_sda_oe", 0);    observe(int'(sda_oe));
        expect_val("reset_tof_index", 0); observe(int'(tof_index));
        expect_val("reset_busy", 0);      observe(int'(busy));
        i2c_stop();
        ready_in = 8'($urandom);
        do_read(8'h00, 1, 1'b0, 1'b0);
        do_read(8'h03, 2, 1'b1, 1'b0);

        repeat (10) @(negedge clk);
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d/%0d required 0", exp_q.size(), obs_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
